// File: rtl/mult_div.sv
// Sequential signed multiply/divide unit.
// A start request in IDLE latches A/B; the datapath then iterates one bit per
// clock for WIDTH clocks (radix-2 Booth for MULT, restoring division on
// magnitudes for DIV). HI/LO are only written on the final iteration, followed
// by a one-cycle DONE state that pulses multStop or DivStop. A zero divisor
// skips RUN entirely and reports DivZero with DivStop right after the start.
module mult_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             MultCtrl,
    input  logic             DivCtrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             busy,
    output logic             multStop,
    output logic             DivStop,
    output logic             DivZero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg;
    logic             op_div_reg;      // 0: multiply, 1: divide
    logic [WIDTH:0]   acc_reg;         // Booth accumulator / partial remainder (one guard bit)
    logic [WIDTH-1:0] q_reg;           // Booth multiplier / dividend-quotient shift register
    logic             q1_reg;          // Booth q(-1) bit
    logic [WIDTH-1:0] opnd_reg;        // multiplicand (signed) or divisor magnitude
    logic             neg_q_reg;       // quotient must be negated
    logic             neg_r_reg;       // remainder must be negated

    logic [WIDTH:0]   acc_next;
    logic [WIDTH-1:0] q_next;
    logic             q1_next;
    logic             busy_next, mult_stop_next, div_stop_next, div_zero_next;
    logic [WIDTH-1:0] res_hi, res_lo;

    // Request decode: MULT has priority when both requests are high
    logic             start, start_div, div_zero_start, last_iter;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign start          = (state_reg == IDLE) && (MultCtrl || DivCtrl);
    assign start_div      = !MultCtrl && DivCtrl;
    assign div_zero_start = start && start_div && (B == '0);
    assign last_iter      = (state_reg == RUN) && (cnt_reg == CW'(WIDTH - 1));
    assign abs_a          = A[WIDTH-1] ? -A : A;
    assign abs_b          = B[WIDTH-1] ? -B : B;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = div_zero_start ? DONE : RUN;
            RUN:     if (last_iter) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output logic: next values of the registered status outputs
    always_comb begin
        busy_next      = (state_next != IDLE);
        mult_stop_next = last_iter && !op_div_reg;
        div_stop_next  = (last_iter && op_div_reg) || div_zero_start;
        div_zero_next  = div_zero_start;
    end

    // One iteration step of Booth multiply or restoring divide
    always_comb begin
        logic [WIDTH:0] ext_m, sum, shifted, diff;
        ext_m    = {opnd_reg[WIDTH-1], opnd_reg};
        sum      = acc_reg;
        shifted  = {acc_reg[WIDTH-1:0], q_reg[WIDTH-1]};
        diff     = shifted - {1'b0, opnd_reg};
        acc_next = acc_reg;
        q_next   = q_reg;
        q1_next  = 1'b0;
        if (!op_div_reg) begin
            case ({q_reg[0], q1_reg})
                2'b01:   sum = acc_reg + ext_m;
                2'b10:   sum = acc_reg - ext_m;
                default: sum = acc_reg;
            endcase
            // arithmetic right shift of {acc, Q, q-1}
            acc_next = {sum[WIDTH], sum[WIDTH:1]};
            q_next   = {sum[0], q_reg[WIDTH-1:1]};
            q1_next  = q_reg[0];
        end else begin
            // a set guard bit means the trial subtraction went negative: restore
            if (!diff[WIDTH]) begin
                acc_next = diff;
                q_next   = {q_reg[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = shifted;
                q_next   = {q_reg[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Final result from the last iteration, with divide sign fix-up
    always_comb begin
        if (op_div_reg) begin
            res_lo = neg_q_reg ? -q_next : q_next;
            res_hi = neg_r_reg ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
        end else begin
            res_lo = q_next;
            res_hi = acc_next[WIDTH-1:0];
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg    <= '0;
            op_div_reg <= 1'b0;
            acc_reg    <= '0;
            q_reg      <= '0;
            q1_reg     <= 1'b0;
            opnd_reg   <= '0;
            neg_q_reg  <= 1'b0;
            neg_r_reg  <= 1'b0;
            HI         <= '0;
            LO         <= '0;
            busy       <= 1'b0;
            multStop   <= 1'b0;
            DivStop    <= 1'b0;
            DivZero    <= 1'b0;
        end else begin
            busy     <= busy_next;
            multStop <= mult_stop_next;
            DivStop  <= div_stop_next;
            DivZero  <= div_zero_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        cnt_reg    <= '0;
                        op_div_reg <= start_div;
                        acc_reg    <= '0;
                        q1_reg     <= 1'b0;
                        if (start_div) begin
                            q_reg     <= abs_a;
                            opnd_reg  <= abs_b;
                            neg_q_reg <= A[WIDTH-1] ^ B[WIDTH-1];
                            neg_r_reg <= A[WIDTH-1];
                        end else begin
                            q_reg     <= B;
                            opnd_reg  <= A;
                            neg_q_reg <= 1'b0;
                            neg_r_reg <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    acc_reg <= acc_next;
                    q_reg   <= q_next;
                    q1_reg  <= q1_next;
                    cnt_reg <= cnt_reg + CW'(1);
                    if (last_iter) begin
                        HI <= res_hi;
                        LO <= res_lo;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div.sv
// Directed-vector bench for mult_div: a table of operations with
// hand-computed results, plus hand-written reset-abort and ignored-request
// sequences. Outputs are sampled on the falling clock edge.
module tb_mult_div;

    logic        clk = 1'b0;
    logic        reset;
    logic        MultCtrl, DivCtrl;
    logic [31:0] A, B;
    logic [31:0] HI, LO;
    logic        busy, multStop, DivStop, DivZero;

    int checks = 0;
    int errors = 0;

    // bench model of the architecturally visible HI/LO contents
    logic [31:0] model_hi, model_lo;

    mult_div #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .MultCtrl (MultCtrl),
        .DivCtrl  (DivCtrl),
        .A        (A),
        .B        (B),
        .HI       (HI),
        .LO       (LO),
        .busy     (busy),
        .multStop (multStop),
        .DivStop  (DivStop),
        .DivZero  (DivZero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mc;
        logic        dc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Issue one request and check every cycle until one edge after completion.
    // inject_k >= 0 raises DivCtrl for one cycle after edge E(inject_k).
    task automatic do_op(input logic mc, input logic dc, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input logic exp_dz,
                         input int inject_k, input string name);
        logic is_div;
        int   stop_at;
        logic [31:0] eh, el;
        is_div  = !mc && dc;
        stop_at = exp_dz ? 0 : 32;
        @(negedge clk);
        MultCtrl = mc; DivCtrl = dc; A = a; B = b;
        @(posedge clk);                       // E0
        @(negedge clk);
        MultCtrl = 1'b0; DivCtrl = 1'b0;
        for (int k = 0; k <= stop_at + 1; k++) begin
            eh = (k < stop_at) ? model_hi : exp_hi;
            el = (k < stop_at) ? model_lo : exp_lo;
            chk({name, " HI"}, HI, eh);
            chk({name, " LO"}, LO, el);
            chk({name, " busy"}, 32'(busy), 32'(k <= stop_at));
            chk({name, " multStop"}, 32'(multStop), 32'(k == stop_at && !is_div));
            chk({name, " DivStop"}, 32'(DivStop), 32'(k == stop_at && is_div));
            chk({name, " DivZero"}, 32'(DivZero), 32'(k == stop_at && exp_dz));
            DivCtrl = (k == inject_k);
            @(negedge clk);
        end
        DivCtrl  = 1'b0;
        model_hi = exp_hi;
        model_lo = exp_lo;
        $display("op %-18s mc=%0b dc=%0b A=%h B=%h -> HI=%h LO=%h DivZero=%0b",
                 name, mc, dc, a, b, HI, LO, exp_dz);
    endtask

    initial begin
        //           mc    dc    A             B             HI            LO            dz
        vecs[0]  = '{1'b1, 1'b0, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 32'h00000005, 32'h00000002, 32'h00000001, 32'h00000002, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'h00000005, 32'h00000000, 32'h00000001, 32'h00000002, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 32'h7FFFFFFF, 32'h80000000, 32'hC0000000, 32'h80000000, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 32'h00000003, 32'h00000005, 32'h00000003, 32'h00000000, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 32'h80000000, 32'h00000002, 32'h00000000, 32'hC0000000, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 32'hFFFFFFFE, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF6, 1'b0};

        reset = 1'b1; MultCtrl = 1'b0; DivCtrl = 1'b0; A = '0; B = '0;
        model_hi = '0; model_lo = '0;
        repeat (2) @(negedge clk);
        chk("reset HI", HI, 32'h0);
        chk("reset LO", LO, 32'h0);
        chk("reset busy", 32'(busy), 32'h0);
        chk("reset stops", 32'({multStop, DivStop, DivZero}), 32'h0);
        reset = 1'b0;

        for (int i = 0; i < NV; i++)
            do_op(vecs[i].mc, vecs[i].dc, vecs[i].a, vecs[i].b,
                  vecs[i].hi, vecs[i].lo, vecs[i].dz, -1, $sformatf("vec%0d", i));

        // DivCtrl pulsed mid-multiply must be ignored
        do_op(1'b1, 1'b0, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A,
              1'b0, 5, "mult+div_pulse");

        // reset at cnt=10 aborts the multiply and clears outputs at once
        @(negedge clk);
        MultCtrl = 1'b1; A = 32'h00000003; B = 32'h00000004;
        @(posedge clk);
        @(negedge clk);
        MultCtrl = 1'b0;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort HI", HI, 32'h0);
        chk("abort LO", LO, 32'h0);
        chk("abort busy", 32'(busy), 32'h0);
        chk("abort stops", 32'({multStop, DivStop, DivZero}), 32'h0);
        model_hi = '0; model_lo = '0;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            chk("abort no stop", 32'({busy, multStop, DivStop, DivZero}), 32'h0);
        end
        $display("op %-18s reset at cnt=10 -> HI=%h LO=%h", "mult_abort", HI, LO);

        do_op(1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, -1, "div_after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
